// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift_sequencer slice: command opcodes,
// external register mode encodings and controller states.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_CLEAR = 2'b01,
        OP_SHR   = 2'b10,
        OP_SHL   = 2'b11
    } op_e;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_CLR  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_SHL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_e;

    function automatic logic is_shift_op(input op_e op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/shift_step_counter.sv
// Loadable down-counter tracking remaining shift steps; saturates at zero.
module shift_step_counter #(
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_is_one,
    output logic             o_is_zero
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_is_one  = (r_cnt == CNT_W'(1));
    assign o_is_zero = (r_cnt == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for an external 8-bit parallel shift register.
// Optional feature: define SHIFT_SEQ_EARLY_ZERO_EN to end shifts once the register reaches zero.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_data,
    input  logic [CNT_W-1:0] i_cmd_cnt,
    output logic [1:0]       o_sr_mode,
    output logic [WIDTH-1:0] o_sr_data,
    input  logic [WIDTH-1:0] i_sr_q,
    output logic             o_busy,
    output logic             o_done_valid,
    output logic [WIDTH-1:0] o_done_q
);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic             r_done_valid;

    logic w_accept;
    logic w_cmd_is_shift;
    logic w_cnt_is_one;
    logic w_cnt_is_zero;
    logic w_exec_shift;
    logic w_shift_last;

    assign o_cmd_ready    = (r_state == IDLE) && !i_rst;
    assign w_accept       = i_cmd_valid && o_cmd_ready;
    assign w_cmd_is_shift = is_shift_op(op_e'(i_cmd_op));
    assign w_exec_shift   = (r_state == EXEC) && is_shift_op(r_op);

    shift_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_accept),
        .i_load_val (i_cmd_cnt),
        .i_dec      (w_exec_shift),
        .o_is_one   (w_cnt_is_one),
        .o_is_zero  (w_cnt_is_zero)
    );

`ifdef SHIFT_SEQ_EARLY_ZERO_EN
    logic [WIDTH-1:0] w_next_q;

    // Zero is a fixed point of a zero-filling shift, so stop once the next value is zero.
    assign w_next_q     = (r_op == OP_SHL) ? (i_sr_q << 1) : (i_sr_q >> 1);
    assign w_shift_last = w_cnt_is_one || w_cnt_is_zero || (w_next_q == '0);
`else
    assign w_shift_last = w_cnt_is_one || w_cnt_is_zero;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_op         <= OP_LOAD;
            r_data       <= '0;
            r_busy       <= 1'b0;
            r_done_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op   <= op_e'(i_cmd_op);
                        r_data <= i_cmd_data;
                        r_busy <= 1'b1;
                        if (w_cmd_is_shift && (i_cmd_cnt == '0)) begin
                            r_state      <= DONE;
                            r_done_valid <= 1'b1;
                        end else begin
                            r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (!is_shift_op(r_op) || w_shift_last) begin
                        r_state      <= DONE;
                        r_done_valid <= 1'b1;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_done_valid <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_done_valid <= 1'b0;
                end
            endcase
        end
    end

    // Register pins: hold (reload own output) unless a command step or reset is in progress.
    always_comb begin
        o_sr_mode = MODE_LOAD;
        o_sr_data = i_sr_q;
        if (i_rst) begin
            o_sr_mode = MODE_CLR;
            o_sr_data = '0;
        end else if (r_state == EXEC) begin
            case (r_op)
                OP_LOAD:  o_sr_data = r_data;
                OP_CLEAR: o_sr_mode = MODE_CLR;
                OP_SHR:   o_sr_mode = MODE_SHR;
                OP_SHL:   o_sr_mode = MODE_SHL;
                default:  o_sr_mode = MODE_LOAD;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done_valid = r_done_valid;
    assign o_done_q     = r_done_valid ? i_sr_q : '0;

endmodule
